demux_1ton_hs: RTL and testbench
================================

// Module: demux_1ton_hs
// PURPOSE
//  Registered 1-to-N demultiplexer for FFT sample blocks: routes one block of DATA_WIDTH complex
//  samples (re/im) to one of N_OUT consumers with valid/ready handshake on both sides.
//  Destination is taken from sel (manual mode) or an internal round-robin pointer (auto mode).
//  Sits between a stage output and parallel butterfly/buffer banks; successor of the 1-to-2 comb demux.
// PARAMETERS
//  WIDTH       9   signed bit width of each re/im sample
//  DATA_WIDTH  16  samples per block (unpacked array depth)
//  N_OUT       4   number of output channels, >= 2
//  SEL_W (localparam) = $clog2(N_OUT)
// PORTS
//  clk        in   1                       clock, all state on rising edge
//  rst        in   1                       synchronous reset, active-high
//  mode       in   1                       0 = manual (sel), 1 = round-robin
//  sel        in   SEL_W                   manual destination index
//  in_valid   in   1                       input block valid
//  in_ready   out  1                       block accepted when in_valid && in_ready
//  d_in_re    in   WIDTH x [0:DATA_WIDTH-1]            signed input real
//  d_in_im    in   WIDTH x [0:DATA_WIDTH-1]            signed input imag
//  out_valid  out  N_OUT                   one-hot (or zero) channel valid
//  out_ready  in   N_OUT                   per-channel consumer ready
//  d_out_re   out  WIDTH x [0:N_OUT-1][0:DATA_WIDTH-1] signed output real
//  d_out_im   out  WIDTH x [0:N_OUT-1][0:DATA_WIDTH-1] signed output imag
//  rr_ptr     out  SEL_W                   next round-robin destination
// BEHAVIOUR
//  - Reset: out_valid=0, rr_ptr=0, held block/dest cleared, all d_out=0; in_ready=1 in cycle after.
//  - Storage: one holding register (block + dest index + vld). No data passes combinationally.
//  - in_ready = !vld || out_ready[dest] (combinational from out_ready; full-rate streaming allowed).
//  - Accept: dest_n = mode ? rr_ptr : sel; block and dest_n captured; vld=1 next cycle. Latency 1 clk.
//  - out_valid[k] = vld && (dest==k). d_out_*[k] = held block when out_valid[k], else all zeros.
//  - Drain: vld && out_ready[dest] && !accept -> vld=0. Drain + accept same cycle -> new block loaded,
//    vld stays 1 (back-to-back, no bubble). out_ready of non-dest channels ignored.
//  - Held data/dest stable while out_valid && !out_ready[dest] (no overwrite, no drop).
//  - rr_ptr advances only on accept with mode=1: wraps N_OUT-1 -> 0. Manual accepts leave it unchanged;
//    switching to mode=1 resumes from current rr_ptr. mode/sel sampled only at accept.
//  - sel >= N_OUT (non-power-of-2 N_OUT): without macro, clamped to N_OUT-1.
//  - Reset mid-operation: held block discarded, out_valid drops next cycle, no partial transfer.
//  - Samples copied bit-exact; no arithmetic, no sign change.
// CONFIGURATION
//  DEMUX_SEL_CHECK_EN defined: extra port sel_err (out, 1, reset 0). Manual accept with sel >= N_OUT
//   is consumed (in_ready handshake completes) but discarded: vld unchanged, sel_err pulses 1 cycle
//   after the accept; rr_ptr unaffected.
//  Not defined: no sel_err port; out-of-range sel clamped to N_OUT-1 as above.
// TESTING
//  T1 reset: rst=1 3 cycles mid-transfer -> out_valid=0, rr_ptr=0, d_out all 0, in_ready=1 after release.
//  T2 manual: mode=0, sel=2, block re[i]=i, im[i]=-i, all out_ready=1 -> next cycle out_valid=4'b0100,
//     d_out_re[2][5]=5, d_out_im[2][5]=-5, channels 0,1,3 all zeros.
//  T3 round-robin: mode=1, 6 back-to-back blocks, out_ready=4'b1111 -> dest 0,1,2,3,0,1; rr_ptr=2; in_ready
//     held 1 throughout (no bubble).
//  T4 backpressure: dest=1, out_ready[1]=0 for 5 cycles, out_ready[3]=1 -> in_ready=0, data stable,
//     second block waits; out_ready[1]=1 -> first drains, second loads same cycle.
//  T5 extremes: samples -256/+255 (WIDTH=9) routed unchanged; N_OUT=3 sel=3 -> clamped to channel 2
//     (no macro) or sel_err=1, no out_valid (DEMUX_SEL_CHECK_EN).
//  T6 mode switch: 2 auto blocks (rr_ptr=2), 1 manual sel=0, then auto -> next dest 2.

Source files
------------

// File: rtl/demux_1ton_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux_1ton_hs                                                 |
// | Brief    : Registered 1-to-N block demux with valid/ready on both sides, |
// |            manual (sel) or round-robin destination. Optional macro       |
// |            DEMUX_SEL_CHECK_EN adds sel_err and drops out-of-range sel.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module demux_1ton_hs #(
  parameter int WIDTH      = 9,
  parameter int DATA_WIDTH = 16,
  parameter int N_OUT      = 4,
  localparam int SEL_W     = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] d_in_re  [0:DATA_WIDTH-1],
  input  logic signed [WIDTH-1:0] d_in_im  [0:DATA_WIDTH-1],
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic signed [WIDTH-1:0] d_out_re [0:N_OUT-1][0:DATA_WIDTH-1],
  output logic signed [WIDTH-1:0] d_out_im [0:N_OUT-1][0:DATA_WIDTH-1],
  output logic [SEL_W-1:0]        rr_ptr
`ifdef DEMUX_SEL_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  localparam logic [SEL_W-1:0] c_LAST = SEL_W'(N_OUT - 1);

  logic                    r_vld;
  logic [SEL_W-1:0]        r_dest;
  logic [SEL_W-1:0]        r_rr_ptr;
  logic signed [WIDTH-1:0] r_re [0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] r_im [0:DATA_WIDTH-1];

  logic                    w_accept;
  logic                    w_drain;
  logic                    w_sel_ok;
  logic                    w_drop;
  logic [SEL_W-1:0]        w_dest_n;

  // Power-of-two channel counts cannot produce an out-of-range sel.
  generate
    if ((1 << SEL_W) == N_OUT) begin : g_sel_pow2
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_range
      assign w_sel_ok = (sel <= c_LAST);
    end
  endgenerate

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_valid[k] = r_vld && (r_dest == SEL_W'(k));
    end
  end

  assign w_drain  = |(out_valid & out_ready);
  assign in_ready = !r_vld || w_drain;
  assign w_accept = in_valid && in_ready;
  assign rr_ptr   = r_rr_ptr;

`ifdef DEMUX_SEL_CHECK_EN
  assign w_drop   = !mode && !w_sel_ok;
  assign w_dest_n = mode ? r_rr_ptr : sel;
`else
  assign w_drop   = 1'b0;
  assign w_dest_n = mode ? r_rr_ptr : (w_sel_ok ? sel : c_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= 1'b0;
      r_dest   <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else begin
      if (w_accept && !w_drop) begin
        r_vld  <= 1'b1;
        r_dest <= w_dest_n;
        r_re   <= d_in_re;
        r_im   <= d_in_im;
      end else if (w_drain) begin
        r_vld <= 1'b0;
      end
      if (w_accept && mode) begin
        r_rr_ptr <= (r_rr_ptr == c_LAST) ? '0 : r_rr_ptr + 1'b1;
      end
    end
  end

`ifdef DEMUX_SEL_CHECK_EN
  logic r_sel_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_accept && w_drop;
    end
  end

  assign sel_err = r_sel_err;
`endif

  // Idle channels present zeros rather than stale block contents.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        d_out_re[k][i] = out_valid[k] ? r_re[i] : '0;
        d_out_im[k][i] = out_valid[k] ? r_im[i] : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_1ton_hs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_demux_1ton_hs                                              |
// | Brief    : Self-checking bench for demux_1ton_hs (N_OUT=4 plus N_OUT=3). |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_demux_1ton_hs;

  localparam int W  = 9;
  localparam int D  = 16;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic [1:0]   sel = '0;
  logic         in_valid = 1'b0;
  logic         in_valid3 = 1'b0;
  logic [N-1:0] out_ready = '0;
  logic [N3-1:0] out_ready3 = '0;
  logic signed [W-1:0] d_in_re [0:D-1];
  logic signed [W-1:0] d_in_im [0:D-1];

  logic         in_ready, in_ready3;
  logic [N-1:0] out_valid;
  logic [N3-1:0] out_valid3;
  logic [1:0]   rr_ptr, rr_ptr3;
  logic signed [W-1:0] d_out_re  [0:N-1][0:D-1];
  logic signed [W-1:0] d_out_im  [0:N-1][0:D-1];
  logic signed [W-1:0] d_out3_re [0:N3-1][0:D-1];
  logic signed [W-1:0] d_out3_im [0:N3-1][0:D-1];
`ifdef DEMUX_SEL_CHECK_EN
  logic         sel_err, sel_err3;
`endif

  int total = 0;
  int bad   = 0;

  demux_1ton_hs #(.WIDTH(W), .DATA_WIDTH(D), .N_OUT(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .d_in_re(d_in_re), .d_in_im(d_in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_out_re(d_out_re), .d_out_im(d_out_im),
    .rr_ptr(rr_ptr)
`ifdef DEMUX_SEL_CHECK_EN
    , .sel_err(sel_err)
`endif
  );

  demux_1ton_hs #(.WIDTH(W), .DATA_WIDTH(D), .N_OUT(N3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .d_in_re(d_in_re), .d_in_im(d_in_im),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .d_out_re(d_out3_re), .d_out_im(d_out3_im),
    .rr_ptr(rr_ptr3)
`ifdef DEMUX_SEL_CHECK_EN
    , .sel_err(sel_err3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: at most one pending block; round-robin target is the count of auto accepts mod N.
  bit                  m_full = 1'b0;
  int                  m_dest = 0;
  int                  auto_cnt = 0;
  logic signed [W-1:0] m_re [0:D-1];
  logic signed [W-1:0] m_im [0:D-1];

  function automatic bit exp_ready();
    return !m_full || out_ready[m_dest];
  endfunction

  function automatic int exp_dest();
    if (mode) return auto_cnt % N;
    return (int'(sel) > N - 1) ? N - 1 : int'(sel);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_full   <= 1'b0;
      m_dest   <= 0;
      auto_cnt <= 0;
    end else begin
      m_full <= (in_valid && exp_ready()) || (m_full && !out_ready[m_dest]);
      if (in_valid && exp_ready()) begin
        m_dest <= exp_dest();
        m_re   <= d_in_re;
        m_im   <= d_in_im;
        if (mode) auto_cnt <= auto_cnt + 1;
      end
    end
  end

  function automatic int count_mis();
    int n = 0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < D; i++) begin
        if (d_out_re[k][i] !== ((m_full && m_dest == k) ? m_re[i] : W'(0))) n++;
        if (d_out_im[k][i] !== ((m_full && m_dest == k) ? m_im[i] : W'(0))) n++;
      end
    end
    return n;
  endfunction

  function automatic int count_nonzero();
    int n = 0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < D; i++) begin
        if (d_out_re[k][i] != 0 || d_out_im[k][i] != 0) n++;
      end
    end
    return n;
  endfunction

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_full ? (1 << m_dest) : 0);
    chk("in_ready", in_ready, exp_ready());
    chk("rr_ptr", rr_ptr, auto_cnt % N);
    chk("d_out_mismatches", count_mis(), 0);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ramp(input int base);
    for (int i = 0; i < D; i++) begin
      d_in_re[i] = W'(base + i);
      d_in_im[i] = W'(-(base + i));
    end
  endtask

  int t3_dest [0:5] = '{0, 1, 2, 3, 0, 1};

  initial begin
    set_ramp(0);
    cyc(2);
    rst = 1'b0;

    // manual route to channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 1'b1; out_ready = '1;
    set_ramp(0);
    cyc();
    in_valid = 1'b0;
    chk("t2_ov", out_valid, 4'b0100);
    chk("t2_re25", d_out_re[2][5], 5);
    chk("t2_im25", d_out_im[2][5], -5);
    chk("t2_ch0", d_out_re[0][5], 0);
    chk("t2_ch3", d_out_im[3][7], 0);
    cyc();

    // round-robin streaming
    mode = 1'b1; in_valid = 1'b1; out_ready = '1;
    for (int k = 0; k < 6; k++) begin
      set_ramp(k * 20);
      #1 chk("t3_ready", in_ready, 1);
      cyc();
      chk("t3_ov", out_valid, 1 << t3_dest[k]);
    end
    in_valid = 1'b0;
    chk("t3_rr", rr_ptr, 2);
    cyc();

    // backpressure on channel 1
    mode = 1'b0; sel = 2'd1; in_valid = 1'b1; out_ready = 4'b1000;
    set_ramp(100);
    cyc();
    set_ramp(-50);
    sel = 2'd2;
    repeat (5) begin
      #1 chk("t4_ready", in_ready, 0);
      chk("t4_ov", out_valid, 4'b0010);
      chk("t4_hold", d_out_re[1][3], 103);
      cyc();
    end
    out_ready = 4'b0010;
    #1 chk("t4_ready_rel", in_ready, 1);
    cyc();
    chk("t4_ov2", out_valid, 4'b0100);
    chk("t4_d2", d_out_re[2][3], -47);
    in_valid = 1'b0; out_ready = '1;
    cyc();

    // sample extremes, then out-of-range sel on the 3-channel instance
    for (int i = 0; i < D; i++) begin
      d_in_re[i] = (i % 2 == 0) ? -9'sd256 : 9'sd255;
      d_in_im[i] = (i % 2 == 0) ? 9'sd255 : -9'sd256;
    end
    mode = 1'b0; sel = 2'd3; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("t5_ov", out_valid, 4'b1000);
    chk("t5_re0", d_out_re[3][0], -256);
    chk("t5_re1", d_out_re[3][1], 255);
    chk("t5_im0", d_out_im[3][0], 255);
    in_valid3 = 1'b1; out_ready3 = '0;
    cyc();
    in_valid3 = 1'b0;
`ifdef DEMUX_SEL_CHECK_EN
    chk("t5_sel_err", sel_err3, 1);
    chk("t5_ov3", out_valid3, 0);
    cyc();
    chk("t5_sel_err_clr", sel_err3, 0);
`else
    chk("t5_ov3", out_valid3, 3'b100);
    chk("t5_re3", d_out3_re[2][0], -256);
    chk("t5_ready3", in_ready3, 0);
    out_ready3 = '1;
    cyc();
    chk("t5_drain3", out_valid3, 0);
`endif
    chk("t5_rr3", rr_ptr3, 0);

    // reset while a block is stalled
    set_ramp(7);
    mode = 1'b1; in_valid = 1'b1; out_ready = '0;
    cyc();
    rst = 1'b1;
    cyc(3);
    chk("t1_ov", out_valid, 0);
    chk("t1_rr", rr_ptr, 0);
    chk("t1_dout", count_nonzero(), 0);
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("t1_ready", in_ready, 1);
    cyc();
    chk("t1_ov_after", out_valid, 0);

    // mode switch resumes round-robin from its held position
    mode = 1'b1; in_valid = 1'b1; out_ready = '1;
    cyc();
    chk("t6_ov_a", out_valid, 4'b0001);
    cyc();
    chk("t6_ov_b", out_valid, 4'b0010);
    chk("t6_rr_b", rr_ptr, 2);
    mode = 1'b0; sel = 2'd0;
    cyc();
    chk("t6_ov_m", out_valid, 4'b0001);
    chk("t6_rr_m", rr_ptr, 2);
    mode = 1'b1;
    cyc();
    chk("t6_ov_c", out_valid, 4'b0100);
    chk("t6_rr_c", rr_ptr, 3);
    in_valid = 1'b0;
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 399) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = 4'($urandom);
      for (int i = 0; i < D; i++) begin
        d_in_re[i] = W'($urandom);
        d_in_im[i] = W'($urandom);
      end
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
